wishbone_arbiter: RTL and testbench
===================================

# wishbone_arbiter

Two-master, one-slave Wishbone arbiter that shares a single slave port (e.g. the crossbar's upstream side or a shared RAM) between the CPU IF and LSU masters. Grants are registered and held for the entire Wishbone cycle. Contention is resolved round-robin. A watchdog terminates transfers the slave never acknowledges, so a hung peripheral cannot deadlock the CPU.

## Interface
- TIMEOUT_CYCLES, 255, stalled-strobe cycles before forced termination; 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEADBEEF, data_out returned to the master on a timeout.
- clk  input  1  system clock; one clock domain, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_m0  wishbone_if.slave  32b addr/data, 4b select  master 0 (CPU IF).
- wb_m1  wishbone_if.slave  32b addr/data, 4b select  master 1 (CPU LSU).
- wb_s  wishbone_if.master  32b addr/data, 4b select  shared slave port.
- timeout_clear  input  1  clears timeout_flag.
- grant  output  2  one-hot current owner (01 = m0, 10 = m1, 00 = idle).
- timeout_flag  output  1  sticky: a timeout has occurred.
- timeout_addr  output  32  address of the most recent timed-out transfer.

## Operation
- State machine:
  - States: IDLE, OWN_M0, OWN_M1.
  - A master requests when its cycle && strobe are both high.
- IDLE:
  - Only m0 requesting -> OWN_M0. Only m1 requesting -> OWN_M1.
  - Both requesting -> grant the master that is not last_owner. last_owner resets to 1, so m0 wins the first contention.
  - last_owner updates on every grant.
- OWN_Mx:
  - wb_s.cycle, strobe, address, select, write_enable and data_in are combinational copies of the owner's signals.
  - The owner's ack and data_out are combinational copies of wb_s.ack and wb_s.data_out.
  - wb_s.ack is forwarded only while the owner's strobe is high; otherwise it is ignored.
  - The owner keeps the bus for as long as its cycle stays high, including back-to-back strobes (Wishbone bus lock). The other master is not granted during this time.
  - Owner's cycle low -> IDLE on the next edge. This applies even mid-transfer with no ack: the transfer is aborted, and no flag is set.
- Non-owner master: ack = 0, data_out = 0; it stalls until granted.
- All wb_s outputs are 0 whenever the state is IDLE.
- Watchdog counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on grant and on every forwarded ack.
  - Increments each cycle the owner's strobe is high and wb_s.ack is low.
  - Saturates at TIMEOUT_CYCLES.
- Timeout, when the counter equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0):
  - For that cycle only: the owner sees ack = 1 and data_out = TIMEOUT_DATA.
  - wb_s.cycle and wb_s.strobe are forced to 0.
  - timeout_flag <= 1 and timeout_addr <= owner address.
  - The state moves to IDLE on the next edge, regardless of the owner's cycle.
- Simultaneous events:
  - A real wb_s.ack in the timeout cycle wins: normal ack, counter clears, no flag.
  - timeout_clear and a new timeout in the same cycle: set wins.
  - Owner drops its cycle in the same cycle as a timeout: the timeout still takes effect.

## Timing
- Reset values:
  - State IDLE; grant = 00; last_owner = 1; counter = 0.
  - timeout_flag = 0; timeout_addr = 0.
  - All wb_s outputs 0; both master acks and data_outs 0.
- Reset asserted mid-transfer: all of the above on the next edge. The slave's cycle drops and no ack is delivered.
- Arbitration latency:
  - A request first seen in IDLE at edge N gives grant and wb_s.strobe valid after edge N, i.e. one cycle of arbitration latency.
  - A new grant is possible at the earliest one cycle after the owner's cycle drops (one IDLE cycle between owners).
- Data path: zero added latency. Slave ack in cycle K is seen by the owner in cycle K.
- Timeout: with the strobe asserted in cycle G (the grant cycle) and never acked, the forced ack occurs in cycle G + TIMEOUT_CYCLES. timeout_flag is visible from the following cycle.

## Test plan
- Single m0 read:
  - Stimulus: m0 cycle/strobe at 0x0000_0100; slave acks 2 cycles after the grant with 0x1234_5678.
  - Required: grant = 01 one cycle after the request; m0 gets ack and 0x1234_5678 in the same cycle as the slave ack; IDLE after m0 drops cycle; m1 ack stays 0 throughout.
- Contention round-robin:
  - Stimulus: both masters request at the same edge, three times in a row, each releasing after one ack.
  - Required: grant sequence 01, 10, 01, with exactly one IDLE cycle between owners.
- Bus lock:
  - Stimulus: m1 owns the bus and performs 4 back-to-back acked strobes with cycle held; m0 requests throughout.
  - Required: grant stays 10 for all 4 transfers; m0 is granted only after m1 drops cycle.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8; m0 strobes address 0x1000_0004; the slave never acks.
  - Required: m0 ack with 0xDEADBEEF exactly 8 cycles after the grant; wb_s.cycle low in that cycle; timeout_flag = 1; timeout_addr = 0x1000_0004; flag clears on timeout_clear.
- Ack/timeout race:
  - Stimulus: slave acks in exactly cycle G + TIMEOUT_CYCLES.
  - Required: normal data is delivered to the master; timeout_flag stays 0.
- Abort and reset:
  - Stimulus (a): owner drops cycle mid-transfer. Stimulus (b): reset asserted while a transfer is granted.
  - Required (a): IDLE on the next edge with no flag.
  - Required (b): all outputs at their reset values after the next edge.

Source files
------------

// File: rtl/wishbone_arbiter_if.sv
// rtl/wishbone_arbiter_if.sv - 32-bit Wishbone bus bundle shared by masters, slave and arbiter
interface wishbone_if;
    logic        cycle;
    logic        strobe;
    logic        write_enable;
    logic [31:0] address;
    logic [3:0]  select;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (
        output cycle, strobe, write_enable, address, select, data_in,
        input  data_out, ack
    );

    modport slave (
        input  cycle, strobe, write_enable, address, select, data_in,
        output data_out, ack
    );
endinterface

// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - two-master round-robin Wishbone arbiter with a stalled-strobe watchdog
// Grants are registered and held for the whole Wishbone cycle; the data path is combinational.
module wishbone_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    wishbone_if.slave   wb_m0,
    wishbone_if.slave   wb_m1,
    wishbone_if.master  wb_s,
    input  logic        timeout_clear,
    output logic [1:0]  grant,
    output logic        timeout_flag,
    output logic [31:0] timeout_addr
);
    localparam int unsigned   CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam bit            WDOG_EN = (TIMEOUT_CYCLES != 0);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_M0 = 2'b01,
        OWN_M1 = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic [CW-1:0] wdog_q, wdog_d;
    logic          timeout_flag_q, timeout_flag_d;
    logic [31:0]   timeout_addr_q, timeout_addr_d;

    logic        req_m0, req_m1;
    logic        own_cyc, own_stb, own_we;
    logic [31:0] own_adr, own_wdat;
    logic [3:0]  own_sel;
    logic        fwd_ack, timeout_hit;

    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_wdat;
    logic [3:0]  s_sel;
    logic        own_ack;
    logic [31:0] own_rdat;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdat, m1_rdat;

    assign req_m0 = wb_m0.cycle && wb_m0.strobe;
    assign req_m1 = wb_m1.cycle && wb_m1.strobe;

    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_adr  = '0;
        own_sel  = '0;
        own_wdat = '0;
        case (state_q)
            OWN_M0: begin
                own_cyc  = wb_m0.cycle;
                own_stb  = wb_m0.strobe;
                own_we   = wb_m0.write_enable;
                own_adr  = wb_m0.address;
                own_sel  = wb_m0.select;
                own_wdat = wb_m0.data_in;
            end
            OWN_M1: begin
                own_cyc  = wb_m1.cycle;
                own_stb  = wb_m1.strobe;
                own_we   = wb_m1.write_enable;
                own_adr  = wb_m1.address;
                own_sel  = wb_m1.select;
                own_wdat = wb_m1.data_in;
            end
            default: begin
            end
        endcase
    end

    // A slave ack only counts while the owner strobes; a real ack beats the watchdog.
    assign fwd_ack     = (state_q != IDLE) && own_stb && wb_s.ack;
    assign timeout_hit = WDOG_EN && (state_q != IDLE) && (wdog_q == CNT_MAX) && !fwd_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_owner_q   <= 1'b1;
            wdog_q         <= '0;
            timeout_flag_q <= 1'b0;
            timeout_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            wdog_q         <= wdog_d;
            timeout_flag_q <= timeout_flag_d;
            timeout_addr_q <= timeout_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (req_m0 && (!req_m1 || last_owner_q)) begin
                    state_d      = OWN_M0;
                    last_owner_d = 1'b0;
                end else if (req_m1) begin
                    state_d      = OWN_M1;
                    last_owner_d = 1'b1;
                end
            end
            OWN_M0, OWN_M1: begin
                if (timeout_hit || !own_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter sits at zero in IDLE, so every fresh grant starts from zero.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE || fwd_ack || timeout_hit) begin
            wdog_d = '0;
        end else if (own_stb && !wb_s.ack && (wdog_q != CNT_MAX)) begin
            wdog_d = wdog_q + CW'(1);
        end
    end

    always_comb begin
        timeout_flag_d = timeout_flag_q;
        timeout_addr_d = timeout_addr_q;
        if (timeout_hit) begin
            timeout_flag_d = 1'b1;
            timeout_addr_d = own_adr;
        end else if (timeout_clear) begin
            timeout_flag_d = 1'b0;
        end
    end

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_wdat   = '0;
        own_ack  = 1'b0;
        own_rdat = '0;
        m0_ack   = 1'b0;
        m0_rdat  = '0;
        m1_ack   = 1'b0;
        m1_rdat  = '0;
        if (state_q != IDLE) begin
            s_cyc    = own_cyc && !timeout_hit;
            s_stb    = own_stb && !timeout_hit;
            s_we     = own_we;
            s_adr    = own_adr;
            s_sel    = own_sel;
            s_wdat   = own_wdat;
            own_ack  = fwd_ack || timeout_hit;
            own_rdat = timeout_hit ? TIMEOUT_DATA : wb_s.data_out;
            if (state_q == OWN_M0) begin
                m0_ack  = own_ack;
                m0_rdat = own_rdat;
            end else begin
                m1_ack  = own_ack;
                m1_rdat = own_rdat;
            end
        end
    end

    assign wb_s.cycle        = s_cyc;
    assign wb_s.strobe       = s_stb;
    assign wb_s.write_enable = s_we;
    assign wb_s.address      = s_adr;
    assign wb_s.select       = s_sel;
    assign wb_s.data_in      = s_wdat;

    assign wb_m0.ack      = m0_ack;
    assign wb_m0.data_out = m0_rdat;
    assign wb_m1.ack      = m1_ack;
    assign wb_m1.data_out = m1_rdat;

    assign grant        = state_q;
    assign timeout_flag = timeout_flag_q;
    assign timeout_addr = timeout_addr_q;
endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb/tb_wishbone_arbiter.sv - scoreboard bench for wishbone_arbiter with an 8-cycle watchdog
module tb_wishbone_arbiter;
    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        timeout_clear;
    logic [1:0]  grant;
    logic        timeout_flag;
    logic [31:0] timeout_addr;

    wishbone_if m0();
    wishbone_if m1();
    wishbone_if s();

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_got, mon_exp;

    always #5 clk = ~clk;

    wishbone_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset), .wb_m0(m0), .wb_m1(m1), .wb_s(s),
        .timeout_clear(timeout_clear), .grant(grant),
        .timeout_flag(timeout_flag), .timeout_addr(timeout_addr)
    );

    // Every master ack pops one {master_id, data} entry pushed when the slave response was driven.
    always @(negedge clk) begin
        if (m0.ack === 1'b1 || m1.ack === 1'b1) begin
            mon_got = {m1.ack === 1'b1, (m1.ack === 1'b1) ? m1.data_out : m0.data_out};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_ack got=%h required=no_ack", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL sb_ack_data got=%h required=%h", mon_got, mon_exp);
                end
            end
            total++;
            if ((m0.ack === 1'b1 && grant !== 2'b01) || (m1.ack === 1'b1 && grant !== 2'b10)) begin
                bad++;
                $display("FAIL sb_ack_owner got_grant=%b m0_ack=%b m1_ack=%b", grant, m0.ack, m1.ack);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic c, input logic [31:0] a);
        m0.cycle = c; m0.strobe = c; m0.address = a; m0.select = 4'hF;
        m0.write_enable = 1'b0; m0.data_in = a ^ 32'hFFFF_0000;
    endtask

    task automatic set_m1(input logic c, input logic [31:0] a);
        m1.cycle = c; m1.strobe = c; m1.address = a; m1.select = 4'h3;
        m1.write_enable = 1'b1; m1.data_in = a ^ 32'h0000_FFFF;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_m0(1'b1, 32'h0000_0100);
        s.data_out = 32'hFFFF_FFFF;
        step(); step();
        @(negedge clk);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b required=00", grant); end
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL rst_flag got=%b required=0", timeout_flag); end
        total++; if (timeout_addr !== 32'h0) begin bad++; $display("FAIL rst_taddr got=%h required=0", timeout_addr); end
        total++; if (s.cycle !== 1'b0 || s.strobe !== 1'b0) begin bad++; $display("FAIL rst_s_cyc_stb got=%b%b required=00", s.cycle, s.strobe); end
        total++; if (m0.ack !== 1'b0 || m1.ack !== 1'b0) begin bad++; $display("FAIL rst_acks got=%b%b required=00", m0.ack, m1.ack); end
        total++; if (m0.data_out !== 32'h0) begin bad++; $display("FAIL rst_m0_data got=%h required=0", m0.data_out); end
        step();
        reset = 1'b0;
        set_m0(1'b0, 32'h0);
        s.data_out = 32'h0;
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic        last;
        logic [31:0] d;
        last = 1'b1;
        step();
        set_m0(1'b1, 32'h0000_0200);
        set_m1(1'b1, 32'h0000_0300);
        for (int r = 0; r < 3; r++) begin
            exp_g = last ? 2'b01 : 2'b10;
            last  = exp_g[1];
            d     = 32'hC0DE_0000 + 32'(r);
            step();
            s.ack = 1'b1; s.data_out = d;
            exp_q.push_back({exp_g[1], d});
            @(negedge clk);
            total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_grant round=%0d got=%b required=%b", r, grant, exp_g); end
            total++; if (s.address !== (exp_g[0] ? 32'h200 : 32'h300)) begin bad++; $display("FAIL rr_addr round=%0d got=%h", r, s.address); end
            step();
            s.ack = 1'b0;
            if (r == 2) begin set_m0(1'b0, 32'h0); set_m1(1'b0, 32'h0); end
            else if (exp_g[0]) set_m0(1'b0, 32'h0);
            else set_m1(1'b0, 32'h0);
            @(negedge clk);
            total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_hold round=%0d got=%b required=%b", r, grant, exp_g); end
            step();
            if (r < 2) begin
                if (exp_g[0]) set_m0(1'b1, 32'h0000_0200); else set_m1(1'b1, 32'h0000_0300);
            end
            @(negedge clk);
            total++; if (grant !== 2'b00) begin bad++; $display("FAIL rr_idle_gap round=%0d got=%b required=00", r, grant); end
        end
    endtask

    task automatic test_single_read();
        step();
        set_m0(1'b1, 32'h0000_0100);
        @(negedge clk);
        total++; if (grant !== 2'b00 || s.strobe !== 1'b0) begin bad++; $display("FAIL rd_latency got_grant=%b stb=%b required=00/0", grant, s.strobe); end
        step();
        @(negedge clk);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL rd_grant got=%b required=01", grant); end
        total++; if ({s.cycle, s.strobe, s.address, s.select} !== {2'b11, 32'h100, 4'hF}) begin bad++; $display("FAIL rd_s_copy got=%b%b %h %h", s.cycle, s.strobe, s.address, s.select); end
        step();
        step();
        s.ack = 1'b1; s.data_out = 32'h1234_5678;
        exp_q.push_back({1'b0, 32'h1234_5678});
        @(negedge clk);
        total++; if (m0.ack !== 1'b1 || m0.data_out !== 32'h1234_5678) begin bad++; $display("FAIL rd_ack got=%b %h required=1 12345678", m0.ack, m0.data_out); end
        total++; if (m1.ack !== 1'b0) begin bad++; $display("FAIL rd_m1_ack got=%b required=0", m1.ack); end
        step();
        s.ack = 1'b0; s.data_out = 32'h0;
        set_m0(1'b0, 32'h0);
        step();
        @(negedge clk);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rd_release got=%b required=00", grant); end
    endtask

    task automatic test_bus_lock();
        logic [31:0] d;
        step();
        set_m1(1'b1, 32'h0000_0400);
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) set_m0(1'b1, 32'h0000_0500);
            m1.address = 32'h0000_0400 + 32'(4 * k);
            d = 32'hB0B0_0000 + 32'(k);
            s.ack = 1'b1; s.data_out = d;
            exp_q.push_back({1'b1, d});
            @(negedge clk);
            total++; if (grant !== 2'b10) begin bad++; $display("FAIL lock_grant xfer=%0d got=%b required=10", k, grant); end
            total++; if (s.address !== 32'h0000_0400 + 32'(4 * k)) begin bad++; $display("FAIL lock_addr xfer=%0d got=%h", k, s.address); end
        end
        step();
        s.ack = 1'b0;
        set_m1(1'b0, 32'h0);
        step();
        @(negedge clk);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL lock_idle got=%b required=00", grant); end
        step();
        @(negedge clk);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL lock_m0_after got=%b required=01", grant); end
        step();
        set_m0(1'b0, 32'h0);
        step();
    endtask

    task automatic test_timeout();
        step();
        set_m0(1'b1, 32'h1000_0004);
        step();
        @(negedge clk);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL to_grant got=%b required=01", grant); end
        for (int k = 0; k < int'(TO); k++) begin
            if (k > 0) begin step(); @(negedge clk); end
            total++; if (m0.ack !== 1'b0 || s.cycle !== 1'b1) begin bad++; $display("FAIL to_early cyc=%0d got_ack=%b s_cyc=%b required=0/1", k, m0.ack, s.cycle); end
        end
        step();
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        @(negedge clk);
        total++; if (m0.ack !== 1'b1 || m0.data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL to_forced_ack got=%b %h required=1 deadbeef", m0.ack, m0.data_out); end
        total++; if (s.cycle !== 1'b0 || s.strobe !== 1'b0) begin bad++; $display("FAIL to_s_forced_low got=%b%b required=00", s.cycle, s.strobe); end
        step();
        set_m0(1'b0, 32'h0);
        @(negedge clk);
        total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL to_flag got=%b required=1", timeout_flag); end
        total++; if (timeout_addr !== 32'h1000_0004) begin bad++; $display("FAIL to_addr got=%h required=10000004", timeout_addr); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL to_idle got=%b required=00", grant); end
        step();
        timeout_clear = 1'b1;
        step();
        timeout_clear = 1'b0;
        @(negedge clk);
        total++; if (timeout_flag !== 1'b0 || timeout_addr !== 32'h1000_0004) begin bad++; $display("FAIL to_clear got=%b %h required=0 10000004", timeout_flag, timeout_addr); end
    endtask

    task automatic test_ack_race();
        step();
        set_m0(1'b1, 32'h2000_0008);
        step();
        for (int k = 1; k < int'(TO); k++) step();
        step();
        s.ack = 1'b1; s.data_out = 32'hA5A5_0001;
        exp_q.push_back({1'b0, 32'hA5A5_0001});
        @(negedge clk);
        total++; if (m0.ack !== 1'b1 || m0.data_out !== 32'hA5A5_0001) begin bad++; $display("FAIL race_data got=%b %h required=1 a5a50001", m0.ack, m0.data_out); end
        total++; if (s.cycle !== 1'b1) begin bad++; $display("FAIL race_s_cyc got=%b required=1", s.cycle); end
        step();
        s.ack = 1'b0; s.data_out = 32'h0;
        set_m0(1'b0, 32'h0);
        step();
        @(negedge clk);
        total++; if (timeout_flag !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL race_flag got=%b grant=%b required=0 00", timeout_flag, grant); end
    endtask

    task automatic test_abort_reset();
        step();
        set_m1(1'b1, 32'h3000_0000);
        step();
        step();
        set_m1(1'b0, 32'h0);
        @(negedge clk);
        total++; if (grant !== 2'b10 || s.cycle !== 1'b0) begin bad++; $display("FAIL abort_hold got=%b cyc=%b required=10 0", grant, s.cycle); end
        step();
        @(negedge clk);
        total++; if (grant !== 2'b00 || timeout_flag !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b flag=%b required=00 0", grant, timeout_flag); end
        step();
        set_m0(1'b1, 32'h3000_0010);
        s.data_out = 32'h5555_5555;
        step();
        @(negedge clk);
        total++; if (grant !== 2'b01 || s.cycle !== 1'b1) begin bad++; $display("FAIL rstx_grant got=%b cyc=%b required=01 1", grant, s.cycle); end
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        total++; if (grant !== 2'b00 || s.cycle !== 1'b0 || s.strobe !== 1'b0 || s.address !== 32'h0) begin bad++; $display("FAIL rstx_bus got=%b %b%b %h required=00 00 0", grant, s.cycle, s.strobe, s.address); end
        total++; if (m0.ack !== 1'b0 || m0.data_out !== 32'h0) begin bad++; $display("FAIL rstx_m0 got=%b %h required=0 0", m0.ack, m0.data_out); end
        total++; if (timeout_flag !== 1'b0 || timeout_addr !== 32'h0) begin bad++; $display("FAIL rstx_wdog got=%b %h required=0 0", timeout_flag, timeout_addr); end
        step();
        reset = 1'b0;
        set_m0(1'b0, 32'h0);
        s.data_out = 32'h0;
    endtask

    initial begin
        timeout_clear = 1'b0;
        s.ack = 1'b0;
        s.data_out = 32'h0;
        set_m0(1'b0, 32'h0);
        set_m1(1'b0, 32'h0);
        test_reset();
        test_round_robin();
        test_single_read();
        test_bus_lock();
        test_timeout();
        test_ack_race();
        test_abort_reset();
        step();
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
